// File: rtl/dma_pkg.sv
// Shared definitions for the weight-preload DMA arbitration slice:
// FSM state encoding and the engine word-count width.
package dma_pkg;

    localparam int CNT_W = 17;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_REL   = 3'd3,
        S_ACK   = 3'd4
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
// The pointer register lives in the parent.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    int   k;
    logic found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        k     = 0;
        for (int i = 0; i < N; i++) begin
            k = int'(ptr) + i;
            if (k >= N) k = k - N;
            if (!found && req[k]) begin
                found  = 1'b1;
                gnt[k] = 1'b1;
                idx    = IW'(k);
            end
        end
    end

endmodule

// File: rtl/dma_preload_arbiter.sv
// Shares the single weight-preload DMA engine among N_REQ loaders with a
// round-robin grant, 4-phase handshakes on both sides and write steering.
module dma_preload_arbiter
    import dma_pkg::*;
#(
    parameter int N_REQ      = 3,
    parameter int ADDR_W     = 16,
    parameter int BUF_ADDR_W = 16,
    parameter int DATA_W     = 128,
    parameter int TIMEOUT    = 65535
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_i,
    input  logic [N_REQ*ADDR_W-1:0] base_i,
    input  logic [N_REQ*CNT_W-1:0]  count_i,
    output logic [N_REQ-1:0]        done_o,
    output logic [N_REQ-1:0]        grant_o,
    output logic                    preload_req,
    output logic [ADDR_W-1:0]       preload_base,
    output logic [CNT_W-1:0]        preload_count,
    input  logic                    preload_done,
    input  logic                    dma_wr_en,
    input  logic [BUF_ADDR_W-1:0]   dma_wr_addr,
    input  logic [DATA_W-1:0]       dma_wr_data,
    output logic [N_REQ-1:0]        buf_wr_en_o,
    output logic [BUF_ADDR_W-1:0]   buf_wr_addr_o,
    output logic [DATA_W-1:0]       buf_wr_data_o,
    output logic                    busy_o,
    output logic                    timeout_err_o
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) + 1 : 1;

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  rr_ptr, arb_idx;
    logic [N_REQ-1:0]  arb_gnt, eligible;
    logic              any_req, owner_req, in_wd, wd_expired;
    logic [ADDR_W-1:0] base_lat;
    logic [CNT_W-1:0]  count_lat;
    logic [WD_W-1:0]   wd_cnt;

    assign eligible   = req_i & ~done_o;
    assign any_req    = |eligible;
    assign owner_req  = |(req_i & grant_o);
    assign in_wd      = (state == S_WAIT) || (state == S_REL);
    assign wd_expired = (TIMEOUT != 0) && in_wd && (wd_cnt == WD_W'(TIMEOUT - 1));

    rr_arbiter #(.N(N_REQ), .IW(IDX_W)) u_rr (
        .req (eligible),
        .ptr (rr_ptr),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (any_req) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (wd_expired) state_nxt = S_ACK;
                     else if (preload_done) state_nxt = S_REL;
            S_REL:   if (wd_expired || !preload_done) state_nxt = S_ACK;
            S_ACK:   if (!owner_req) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Base/count are gated so the engine sees zeros outside a transfer.
    always_comb begin
        preload_req   = (state == S_ISSUE) || (state == S_WAIT);
        done_o        = (state == S_ACK) ? grant_o : '0;
        busy_o        = (state != S_IDLE);
        preload_base  = '0;
        preload_count = '0;
        if ((state == S_ISSUE) || in_wd) begin
            preload_base  = base_lat;
            preload_count = count_lat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_o <= '0;
            rr_ptr  <= '0;
        end else if (state == S_IDLE && any_req) begin
            grant_o <= arb_gnt;
            rr_ptr  <= (arb_idx == IDX_W'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
        end else if (state == S_ACK && !owner_req) begin
            grant_o <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_IDLE && any_req) begin
            base_lat  <= base_i[arb_idx*ADDR_W +: ADDR_W];
            count_lat <= count_i[arb_idx*CNT_W +: CNT_W];
        end
    end

    // Watchdog counts consecutive cycles in WAIT/REL and restarts on any state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt        <= '0;
            timeout_err_o <= 1'b0;
        end else begin
            if (in_wd && state_nxt == state) wd_cnt <= wd_cnt + 1'b1;
            else                             wd_cnt <= '0;
            if (wd_expired) timeout_err_o <= 1'b1;
        end
    end

    assign buf_wr_en_o   = {N_REQ{dma_wr_en}} & grant_o;
    assign buf_wr_addr_o = dma_wr_addr;
    assign buf_wr_data_o = dma_wr_data;

endmodule

// File: tb/tb_dma_preload_arbiter.sv
// Directed bench for dma_preload_arbiter: a main instance with the default
// watchdog and a second instance with TIMEOUT=32 whose engine never answers.
module tb_dma_preload_arbiter;

    localparam int N  = 3;
    localparam int AW = 16;
    localparam int BW = 16;
    localparam int DW = 128;
    localparam int CW = 17;

    logic            clk, rst_n;
    logic [N-1:0]    req_i, done_o, grant_o, buf_wr_en_o;
    logic [N*AW-1:0] base_i;
    logic [N*CW-1:0] count_i;
    logic            preload_req, preload_done, busy_o, timeout_err_o;
    logic [AW-1:0]   preload_base;
    logic [CW-1:0]   preload_count;
    logic            dma_wr_en;
    logic [BW-1:0]   dma_wr_addr, buf_wr_addr_o;
    logic [DW-1:0]   dma_wr_data, buf_wr_data_o;

    logic [N-1:0]    req_w, done_w, grant_w, bwe_w;
    logic [N*AW-1:0] base_w;
    logic [N*CW-1:0] count_w;
    logic            preq_w, busy_w, err_w;
    logic [AW-1:0]   pbase_w;
    logic [CW-1:0]   pcount_w;
    logic [BW-1:0]   bwa_w;
    logic [DW-1:0]   bwd_w;

    int   vectors = 0;
    int   miscompares = 0;
    int   rises = 0;
    logic preq_q = 1'b0;

    dma_preload_arbiter #(.N_REQ(N), .ADDR_W(AW), .BUF_ADDR_W(BW), .DATA_W(DW)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .base_i(base_i), .count_i(count_i),
        .done_o(done_o), .grant_o(grant_o), .preload_req(preload_req),
        .preload_base(preload_base), .preload_count(preload_count),
        .preload_done(preload_done), .dma_wr_en(dma_wr_en), .dma_wr_addr(dma_wr_addr),
        .dma_wr_data(dma_wr_data), .buf_wr_en_o(buf_wr_en_o), .buf_wr_addr_o(buf_wr_addr_o),
        .buf_wr_data_o(buf_wr_data_o), .busy_o(busy_o), .timeout_err_o(timeout_err_o)
    );

    dma_preload_arbiter #(.N_REQ(N), .ADDR_W(AW), .BUF_ADDR_W(BW), .DATA_W(DW), .TIMEOUT(32)) u_dut_wd (
        .clk(clk), .rst_n(rst_n), .req_i(req_w), .base_i(base_w), .count_i(count_w),
        .done_o(done_w), .grant_o(grant_w), .preload_req(preq_w),
        .preload_base(pbase_w), .preload_count(pcount_w),
        .preload_done(1'b0), .dma_wr_en(dma_wr_en), .dma_wr_addr(dma_wr_addr),
        .dma_wr_data(dma_wr_data), .buf_wr_en_o(bwe_w), .buf_wr_addr_o(bwa_w),
        .buf_wr_data_o(bwd_w), .busy_o(busy_w), .timeout_err_o(err_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        preq_q <= preload_req;
        if (preload_req && !preq_q) rises <= rises + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_slot(input int k, input logic [AW-1:0] b, input logic [CW-1:0] c);
        base_i[k*AW +: AW]  = b;
        count_i[k*CW +: CW] = c;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Engine model: answer a preload request with `words` buffer writes.
    task automatic engine(input string tag, input logic [AW-1:0] eb, input logic [CW-1:0] ec,
                          input int words, input int lat, input int drop);
        int n;
        int strobes;
        n = 0;
        while (!preload_req && n < 40) begin @(negedge clk); n++; end
        chk({tag, "_preq"}, 64'(preload_req), 64'd1);
        chk({tag, "_base"}, 64'(preload_base), 64'(eb));
        chk({tag, "_count"}, 64'(preload_count), 64'(ec));
        if (drop >= 0) begin
            @(negedge clk);
            req_i[drop] = 1'b0;
        end
        repeat (lat) @(negedge clk);
        strobes = 0;
        for (int i = 0; i < words; i++) begin
            dma_wr_en   = 1'b1;
            dma_wr_addr = BW'(i);
            dma_wr_data = {4{32'(i)}};
            #1;
            if (grant_o != '0 && buf_wr_en_o == grant_o) strobes++;
            @(negedge clk);
        end
        dma_wr_en = 1'b0;
        chk({tag, "_strobes"}, 64'(strobes), 64'(words));
        preload_done = 1'b1;
        n = 0;
        while (preload_req && n < 40) begin @(negedge clk); n++; end
        chk({tag, "_req_drop"}, 64'(preload_req), 64'd0);
        preload_done = 1'b0;
    endtask

    task automatic finish_req(input string tag, input int k, input logic drop_all);
        int n;
        n = 0;
        while (done_o == '0 && n < 40) begin @(negedge clk); n++; end
        chk({tag, "_done"}, 64'(done_o), 64'(1 << k));
        if (drop_all) req_i = '0;
        else          req_i[k] = 1'b0;
        @(negedge clk);
        chk({tag, "_done_clr"}, 64'(done_o), 64'd0);
        chk({tag, "_grant_clr"}, 64'(grant_o), 64'd0);
    endtask

    task automatic wait_grant();
        int n;
        n = 0;
        while (grant_o == '0 && n < 40) begin @(negedge clk); n++; end
    endtask

    initial begin
        int n;
        int r0;
        int dcnt;
        logic saw_g2;
        rst_n = 1'b0; req_i = '0; base_i = '0; count_i = '0; preload_done = 1'b0;
        dma_wr_en = 1'b0; dma_wr_addr = '0; dma_wr_data = '0;
        req_w = '0; base_w = '0; count_w = '0;
        repeat (3) @(negedge clk);
        chk("rst_grant", 64'(grant_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_preq", 64'(preload_req), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_err", 64'(timeout_err_o), 64'd0);
        chk("rst_base", 64'(preload_base), 64'd0);
        rst_n = 1'b1;

        // Write with no owner is dropped; address still broadcast.
        @(negedge clk);
        dma_wr_en = 1'b1; dma_wr_addr = 16'h1234;
        #1;
        chk("idle_wr_en", 64'(buf_wr_en_o), 64'd0);
        chk("idle_wr_addr", 64'(buf_wr_addr_o), 64'h1234);
        dma_wr_en = 1'b0;

        // 1: single requester, 16 words.
        @(negedge clk);
        set_slot(0, 16'h0100, 17'd16);
        req_i = 3'b001;
        #1;
        chk("t1_grant_early", 64'(grant_o), 64'd0);
        @(negedge clk);
        chk("t1_grant", 64'(grant_o), 64'b001);
        chk("t1_busy", 64'(busy_o), 64'd1);
        set_slot(0, 16'hDEAD, 17'd99);
        engine("t1", 16'h0100, 17'd16, 16, 2, -1);
        finish_req("t1", 0, 1'b0);

        // 2: all three requesting from pointer 0.
        do_reset();
        set_slot(0, 16'h1000, 17'd4);
        set_slot(1, 16'h2000, 17'd5);
        set_slot(2, 16'h3000, 17'd6);
        req_i = 3'b111;
        for (int r = 0; r < 4; r++) begin
            int k;
            k = r % 3;
            wait_grant();
            chk($sformatf("t2_grant%0d", r), 64'(grant_o), 64'(1 << k));
            engine($sformatf("t2_%0d", r), AW'(16'h1000 * (k + 1)), CW'(4 + k), 4 + k, 1, -1);
            finish_req($sformatf("t2_%0d", r), k, r == 3);
            if (r < 3) req_i[k] = 1'b1;
        end

        // 3: cached load, done one cycle after request.
        set_slot(2, 16'h3300, 17'd8);
        r0 = rises;
        req_i = 3'b100;
        wait_grant();
        chk("t3_grant", 64'(grant_o), 64'b100);
        engine("t3", 16'h3300, 17'd8, 0, 0, -1);
        finish_req("t3", 2, 1'b0);
        chk("t3_one_pulse", 64'(rises - r0), 64'd1);

        // 4: requester 1 drops its request while the engine is working.
        set_slot(1, 16'h5000, 17'd3);
        set_slot(2, 16'h6000, 17'd2);
        req_i = 3'b110;
        wait_grant();
        chk("t4_grant", 64'(grant_o), 64'b010);
        engine("t4", 16'h5000, 17'd3, 3, 1, 1);
        dcnt = 0; saw_g2 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done_o[1]) dcnt++;
            if (grant_o == 3'b100) saw_g2 = 1'b1;
        end
        chk("t4_done_pulse", 64'(dcnt), 64'd1);
        chk("t4_next_grant", 64'(saw_g2), 64'd1);
        engine("t4b", 16'h6000, 17'd2, 2, 1, -1);
        finish_req("t4b", 2, 1'b0);

        // 6: asynchronous reset mid-transfer, then fresh arbitration.
        set_slot(0, 16'h0400, 17'd100);
        req_i = 3'b001;
        n = 0;
        while (!preload_req && n < 40) begin @(negedge clk); n++; end
        chk("t6_preq", 64'(preload_req), 64'd1);
        for (int i = 0; i < 40; i++) begin
            dma_wr_en = 1'b1; dma_wr_addr = BW'(i);
            @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("t6_grant", 64'(grant_o), 64'd0);
        chk("t6_preq_rst", 64'(preload_req), 64'd0);
        chk("t6_base", 64'(preload_base), 64'd0);
        chk("t6_count", 64'(preload_count), 64'd0);
        chk("t6_busy", 64'(busy_o), 64'd0);
        chk("t6_wr_en", 64'(buf_wr_en_o), 64'd0);
        dma_wr_en = 1'b0;
        req_i = 3'b101;
        @(negedge clk);
        rst_n = 1'b1;
        wait_grant();
        chk("t6_fresh_grant", 64'(grant_o), 64'b001);
        engine("t6b", 16'h0400, 17'd100, 2, 1, -1);
        finish_req("t6b", 0, 1'b1);

        // 5: watchdog instance, engine silent.
        base_w[0 +: AW] = 16'h0ABC;
        count_w[0 +: CW] = 17'd5;
        req_w = 3'b001;
        n = 0;
        while (!preq_w && n < 40) begin @(negedge clk); n++; end
        chk("t5_preq", 64'(preq_w), 64'd1);
        chk("t5_base", 64'(pbase_w), 64'h0ABC);
        chk("t5_err_before", 64'(err_w), 64'd0);
        n = 0;
        while (preq_w && n < 100) begin n++; @(negedge clk); end
        chk("t5_req_cycles", 64'(n), 64'd33);
        chk("t5_err", 64'(err_w), 64'd1);
        chk("t5_done", 64'(done_w), 64'b001);
        req_w = '0;
        @(negedge clk);
        chk("t5_done_clr", 64'(done_w), 64'd0);
        chk("t5_grant_clr", 64'(grant_w), 64'd0);
        chk("t5_err_sticky", 64'(err_w), 64'd1);
        chk("t5_busy", 64'(busy_w), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
